// File: rtl/x25519_loader.sv
// Byte-stream loader for an X25519 scalar-multiply core: collects scalar and u,
// reduces u mod p, starts the core and reports completion. Optional clamping via X25519_CLAMP_EN.
module x25519_loader (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    output logic         core_start,
    output logic [254:0] core_n,
    output logic [254:0] core_q,
    input  logic         core_done,
    output logic         busy,
    output logic         result_valid
);
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        REDUCE  = 2'd1,
        START   = 2'd2,
        WAIT    = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     cnt_q, cnt_d;
    logic [255:0]   scalar_q, scalar_d;
    logic [255:0]   u_q, u_d;
    logic [254:0]   n_q, n_d;
    logic [254:0]   qv_q, qv_d;
    logic           rv_q, rv_d;
    logic [255:0]   u_plus19;
    logic [254:0]   n_load;

    // u >= p exactly when u + 19 carries into bit 255; the low bits are then u - p.
    assign u_plus19 = {1'b0, u_q[254:0]} + 256'd19;

`ifdef X25519_CLAMP_EN
    assign n_load = {1'b1, scalar_q[253:3], 3'b000};
`else
    assign n_load = scalar_q[254:0];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= COLLECT;
            cnt_q    <= 6'd0;
            scalar_q <= '0;
            u_q      <= '0;
            n_q      <= '0;
            qv_q     <= '0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            scalar_q <= scalar_d;
            u_q      <= u_d;
            n_q      <= n_d;
            qv_q     <= qv_d;
            rv_q     <= rv_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scalar_d   = scalar_q;
        u_d        = u_q;
        n_d        = n_q;
        qv_d       = qv_q;
        rv_d       = 1'b0;
        in_ready   = 1'b0;
        core_start = 1'b0;
        case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    cnt_d = cnt_q + 6'd1;
                    // Little-endian: shift in at the top so byte 0 ends at bits [7:0].
                    if (cnt_q[5]) u_d      = {in_data, u_q[255:8]};
                    else          scalar_d = {in_data, scalar_q[255:8]};
                    if (cnt_q == 6'd63) state_d = REDUCE;
                end
            end
            REDUCE: begin
                n_d     = n_load;
                qv_d    = u_plus19[255] ? u_plus19[254:0] : u_q[254:0];
                state_d = START;
            end
            START: begin
                core_start = 1'b1;
                state_d    = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    rv_d    = 1'b1;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    assign busy         = (state_q != COLLECT);
    assign core_n       = n_q;
    assign core_q       = qv_q;
    assign result_valid = rv_q;
endmodule

// File: tb/tb_x25519_loader.sv
// Scoreboard bench for x25519_loader: directed frames push expected (n, q); a monitor
// compares them whenever core_start is seen.
module tb_x25519_loader;
    logic         clock = 1'b0;
    logic         reset, in_valid, in_ready, core_start, core_done, busy, result_valid;
    logic [7:0]   in_data;
    logic [254:0] core_n, core_q;

    x25519_loader dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .core_start(core_start), .core_n(core_n), .core_q(core_q),
        .core_done(core_done), .busy(busy), .result_valid(result_valid)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [254:0] n;
        logic [254:0] q;
    } exp_t;

    localparam logic [254:0] P = {255{1'b1}} - 255'd18;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          rv_count = 0;
    logic [7:0]  fr[64];
    exp_t        last;

    task automatic chk(input string name, input logic [254:0] act, input logic [254:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Monitor: scoreboard compare on each start pulse, count result pulses.
    always @(negedge clock) begin
        exp_t e;
        if (result_valid) rv_count++;
        if (core_start) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_start: got start with empty scoreboard");
            end else begin
                e = sb.pop_front();
                chk("core_n", core_n, e.n);
                chk("core_q", core_q, e.q);
            end
        end
    end

    function automatic logic [254:0] scalar_n();
        logic [255:0] s;
        for (int k = 0; k < 32; k++) s[8*k +: 8] = fr[k];
`ifdef X25519_CLAMP_EN
        s[2:0] = 3'b000;
        s[254] = 1'b1;
`endif
        return s[254:0];
    endfunction

    task automatic set_u_near_p(input logic [7:0] b0);
        fr[32] = b0;
        for (int k = 33; k < 63; k++) fr[k] = 8'hFF;
        fr[63] = 8'h7F;
    endtask

    task automatic set_u_small(input logic [7:0] b0);
        fr[32] = b0;
        for (int k = 33; k < 64; k++) fr[k] = 8'h00;
    endtask

    // Drives bytes on negedges; returns on the negedge after the last transfer.
    task automatic send_bytes(input int count, input bit gaps);
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b1;
            in_data  = fr[i];
            @(negedge clock);
            if (gaps && (i % 3 == 1)) begin
                in_valid = 1'b0;
                in_data  = 8'h5A;
                @(negedge clock);
                @(negedge clock);
            end
        end
        in_valid = 1'b0;
    endtask

    // Full frame plus latency checks; ends on a negedge in WAIT.
    task automatic run_frame(input logic [254:0] en, input logic [254:0] eq, input bit gaps,
                             input bit done_early);
        last.n = en;
        last.q = eq;
        sb.push_back(last);
        send_bytes(64, gaps);
        if (done_early) core_done = 1'b1;
        chk1("reduce_start_low", core_start, 1'b0);
        chk1("reduce_ready_low", in_ready, 1'b0);
        chk1("reduce_busy", busy, 1'b1);
        @(negedge clock);
        chk1("start_latency", core_start, 1'b1);
        @(negedge clock);
        core_done = 1'b0;
        chk1("wait_start_low", core_start, 1'b0);
        chk1("wait_no_rv", result_valid, 1'b0);
    endtask

    task automatic finish_core();
        int r0;
        #1 r0 = rv_count;
        core_done = 1'b1;
        @(negedge clock);
        chk1("rv_pulse", result_valid, 1'b1);
        chk1("ready_back", in_ready, 1'b1);
        core_done = 1'b0;
        @(negedge clock);
        chk1("rv_single", result_valid, 1'b0);
        @(negedge clock);
        #1 chk("rv_count", 255'(rv_count - r0), 255'd1);
    endtask

    initial begin
        int r0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        core_done = 1'b0;
        repeat (3) @(negedge clock);
        chk1("rst_start", core_start, 1'b0);
        chk1("rst_rv", result_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_n", core_n, '0);
        chk("rst_q", core_q, '0);
        reset = 1'b0;
        @(negedge clock);
        chk1("post_rst_ready", in_ready, 1'b1);

        // core_done in COLLECT is ignored
        core_done = 1'b1;
        @(negedge clock);
        core_done = 1'b0;
        @(negedge clock);
        chk1("done_in_collect", result_valid, 1'b0);
        chk1("collect_busy", busy, 1'b0);

        // F1: all 0xFF, back-to-back; then back-pressure in WAIT
        for (int k = 0; k < 64; k++) fr[k] = 8'hFF;
`ifdef X25519_CLAMP_EN
        run_frame({{252{1'b1}}, 3'b000}, 255'h12, 1'b0, 1'b0);
`else
        run_frame({255{1'b1}}, 255'h12, 1'b0, 1'b0);
`endif
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
            @(negedge clock);
            chk1("bp_ready", in_ready, 1'b0);
            chk("bp_n", core_n, last.n);
            chk("bp_q", core_q, last.q);
        end
        in_valid = 1'b0;
        finish_core();

        // F2: pattern scalar, u = p, gapped input, core_done high in REDUCE/START
        for (int k = 0; k < 32; k++) fr[k] = 8'(k * 7 + 3);
        set_u_near_p(8'hED);
        run_frame(scalar_n(), 255'd0, 1'b1, 1'b1);
        chk1("early_done_ignored", busy, 1'b1);
        finish_core();

        // F3: u = 9
        for (int k = 0; k < 32; k++) fr[k] = 8'hA5 ^ 8'(k);
        set_u_small(8'h09);
        run_frame(scalar_n(), 255'd9, 1'b0, 1'b0);
        finish_core();

        // F4: u = p + 1, F5: u = p - 1
        set_u_near_p(8'hEE);
        run_frame(scalar_n(), 255'd1, 1'b0, 1'b0);
        finish_core();
        for (int k = 0; k < 32; k++) fr[k] = 8'(255 - k);
        set_u_near_p(8'hEC);
        run_frame(scalar_n(), P - 255'd1, 1'b0, 1'b0);
        finish_core();

        // Reset after 40 bytes, then a clean frame
        for (int k = 0; k < 64; k++) fr[k] = 8'hC3;
        send_bytes(40, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_cnt", 255'(dut.cnt_q), 255'd0);
        chk("mid_rst_n", core_n, '0);
        chk("mid_rst_q", core_q, '0);
        chk1("mid_rst_ready", in_ready, 1'b1);
        for (int k = 0; k < 32; k++) fr[k] = 8'(k + 1);
        set_u_small(8'h09);
        run_frame(scalar_n(), 255'd9, 1'b0, 1'b0);
        finish_core();

        // Reset during WAIT; the later core_done must not produce result_valid
        for (int k = 0; k < 32; k++) fr[k] = 8'h3C;
        set_u_near_p(8'hEE);
        run_frame(scalar_n(), 255'd1, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk1("wait_rst_busy", busy, 1'b0);
        chk("wait_rst_n", core_n, '0);
        chk("wait_rst_q", core_q, '0);
        #1 r0 = rv_count;
        core_done = 1'b1;
        @(negedge clock);
        core_done = 1'b0;
        repeat (3) @(negedge clock);
        #1 chk("abandoned_rv", 255'(rv_count - r0), 255'd0);
        chk("sb_empty", 255'(sb.size()), 255'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/x25519_loader.md
X25519_LOADER -- requirements
Module: x25519_loader

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: `clock` and `reset`.
REQ-002 Port `clock`: input, width 1, rising-edge clock for all state.
REQ-003 Port `reset`: input, width 1, synchronous active-high reset.
REQ-004 Port `in_valid`: input, width 1, the upstream byte is valid.
REQ-005 Port `in_ready`: output, width 1, the loader accepts a byte this cycle.
REQ-006 Port `in_data`: input, width 8, the byte stream: 32 scalar bytes, then 32 u-coordinate bytes, each little-endian.
REQ-007 Port `core_start`: output, width 1, one-cycle start pulse to the scalar-multiply core.
REQ-008 Port `core_n`: output, width 255, the scalar to the core.
REQ-009 Port `core_q`: output, width 255, the canonical u-coordinate to the core.
REQ-010 Port `core_done`: input, width 1, the done level from the core.
REQ-011 Port `busy`: output, width 1, high outside COLLECT.
REQ-012 Port `result_valid`: output, width 1, one-cycle pulse when the core result is ready.

Function
REQ-013 States SHALL be COLLECT, REDUCE, START and WAIT, encoded in 2 bits.
REQ-014 COLLECT behaviour:
- `in_ready` = 1.
- A byte transfers when `in_valid` && `in_ready`.
- A 6-bit counter `cnt` increments on each transfer.
- Bytes 0..31 load scalar bits [8k+7:8k].
- Bytes 32..63 load u bits [8(k-32)+7:8(k-32)].
REQ-015 Transfer of byte 63 SHALL move the state to REDUCE and wrap `cnt` to 0.
REQ-016 In every state other than COLLECT, `in_ready` SHALL be 0 and `in_data` SHALL be ignored.
REQ-017 Bit 255 of u (bit 7 of byte 63) SHALL be discarded.
REQ-018 Bit 255 of the scalar SHALL never reach `core_n` (the port is 255 bits).
REQ-019 REDUCE (1 cycle): if u >= p = 2^255-19, then `core_q` <= u - p, else `core_q` <= u; the next state is START.
REQ-020 START (1 cycle): `core_start` = 1; the next state is WAIT.
REQ-021 WAIT SHALL stay until `core_done` = 1, then pulse `result_valid` for 1 cycle and return to COLLECT.
REQ-022 `core_done` SHALL be ignored in COLLECT, REDUCE and START.
REQ-023 `core_n` and `core_q` SHALL be stable from START until the return to COLLECT, because the core reads `core_n` bits throughout.
REQ-024 `core_n` and `core_q` SHALL only be modified in COLLECT and REDUCE.
REQ-025 Latency from the byte-63 transfer to `core_start` high SHALL be exactly 2 cycles.
REQ-026 `result_valid` SHALL rise in the cycle after `core_done` is first sampled high in WAIT.
REQ-027 A byte may transfer in the same cycle that `result_valid` is high. The state is already COLLECT then.
REQ-028 Gaps in `in_valid` SHALL stall `cnt` with no timeout.

Reset
REQ-029 On `reset`, regardless of state (including mid-COLLECT or mid-WAIT), the following SHALL hold:
- state = COLLECT, `cnt` = 0.
- `core_start` = 0, `result_valid` = 0, `busy` = 0.
- `core_n` = 0, `core_q` = 0, and the scalar/u shift registers = 0.
REQ-030 After reset, `in_ready` SHALL be 1 in the first cycle.
REQ-031 A core run in flight at reset SHALL be abandoned; its later `core_done` is ignored (REQ-022).
REQ-032 `reset` SHALL have priority over all other transitions in the same cycle.

Configuration
REQ-033 Macro `X25519_CLAMP_EN`, when defined, SHALL enable RFC 7748 clamping at REDUCE:
- scalar bits [2:0] cleared;
- bit 254 set;
- bit 255 cleared.
REQ-034 When `X25519_CLAMP_EN` is undefined, `core_n` SHALL be scalar bits [254:0] unmodified.
REQ-035 Timing and all other behaviour SHALL be identical with and without `X25519_CLAMP_EN`.

Verification
REQ-036 Clamp on, 64 bytes of 0xFF, back-to-back:
- `core_n` = 2^255-8 (0x7FFF…FFF8) and `core_q` = 0x12;
- `core_start` is high 2 cycles after byte 63.
REQ-037 Clamp off, the same stimulus SHALL give `core_n` = 2^255-1 and `core_q` = 0x12.
REQ-038 u bytes ED, FF×30, 7F (u = p) SHALL give `core_q` = 0.
REQ-039 u byte0 = 09, rest 00, SHALL give `core_q` = 9.
REQ-040 Back-pressure and completion:
- In WAIT, hold `in_valid` = 1 with data 0xAA: no transfer occurs and `core_n`/`core_q` are unchanged.
- Then raise `core_done`: exactly one `result_valid` pulse follows and `in_ready` returns to 1.
REQ-041 Reset mid-operation:
- Assert `reset` after 40 bytes: `cnt` is 0.
- Then a full 64-byte frame gives correct outputs with no stale bytes.
- Assert `reset` during WAIT, then pulse `core_done`: no `result_valid` occurs.
